// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deglitch, frame, queue scancodes.
// Define PS2_RX_PARITY_EN to reject frames whose odd parity does not check.
module ps2_rx_cond #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic pin,
   output logic filt
);
   localparam int FCW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FCW-1:0]         cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   in_s;

   assign in_s = sync_q[SYNC_STAGES-1];
   assign filt = filt_q;

   // The first differing sample counts as one; agreement resets the run.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin};
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (in_s == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == FCW'(FILTER_LEN - 1)) begin
         filt_d = in_s;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + FCW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         cnt_q  <= '0;
         filt_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end
endmodule

module ps2_rx_fifo #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             PS2_clock,
   input  logic                             PS2_data,
   input  logic                             rd_en,
   input  logic                             clear_err,
   output logic [7:0]                       Key_code,
   output logic                             valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
   output logic                             overflow,
   output logic                             frame_err
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic clk_f, data_f;
   logic clk_prev_q, clk_prev_d;
   logic fall;

   ps2_rx_cond #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_cond (
      .clock(clock),
      .reset(reset),
      .pin  (PS2_clock),
      .filt (clk_f)
   );

   ps2_rx_cond #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
   ) u_data_cond (
      .clock(clock),
      .reset(reset),
      .pin  (PS2_data),
      .filt (data_f)
   );

   always_comb begin
      clk_prev_d = clk_f;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) clk_prev_q <= 1'b1;
      else       clk_prev_q <= clk_prev_d;
   end

   assign fall = clk_prev_q & ~clk_f;

   state_t       state_q;
   logic [2:0]   bit_cnt_q;
   logic [7:0]   shift_q;
   logic [TW-1:0] tmo_q;
   logic         frame_err_q;
   logic         tmo_hit;
   logic         par_ok;
   logic         push_w;

`ifdef PS2_RX_PARITY_EN
   logic par_q;
   assign par_ok = ^{par_q, shift_q};
`else
   assign par_ok = 1'b1;
`endif

   assign tmo_hit = (state_q != S_IDLE) && !fall &&
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign push_w  = fall && (state_q == S_STOP) && data_f && par_ok;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tmo_q       <= '0;
         frame_err_q <= 1'b0;
`ifdef PS2_RX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         frame_err_q <= 1'b0;
         if (state_q == S_IDLE || fall) tmo_q <= '0;
         else                           tmo_q <= tmo_q + TW'(1);
         if (tmo_hit) begin
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
         end else if (fall) begin
            unique case (state_q)
               S_IDLE: begin
                  if (!data_f) begin
                     state_q   <= S_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               S_DATA: begin
                  shift_q   <= {data_f, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
               end
               S_PARITY: begin
`ifdef PS2_RX_PARITY_EN
                  par_q   <= data_f;
`endif
                  state_q <= S_STOP;
               end
               S_STOP: begin
                  if (!data_f || !par_ok) frame_err_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign frame_err = frame_err_q;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          pop, full, wr, drop;

   assign valid = (count_q != '0);
   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign pop   = rd_en & valid;
   // A pop on the same edge frees the slot the push needs.
   assign wr    = push_w & (~full | pop);
   assign drop  = push_w & full & ~pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr) begin
         mem_d[wr_ptr_q] = shift_q;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (drop)           ovf_d = 1'b1;
      else if (clear_err) ovf_d = 1'b0;
      else                ovf_d = ovf_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign Key_code = valid ? mem_q[rd_ptr_q] : 8'h00;
   assign count    = count_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames, popped bytes
// are checked against a queue of expected scancodes by a separate monitor.
module tb_ps2_rx_fifo;
   localparam int DEPTH = 4;
   localparam int FLEN  = 8;
   localparam int TMO   = 400;
   localparam int SYNC  = 2;
   localparam int HALF  = 20;

   logic       clock = 1'b0;
   logic       reset;
   logic       PS2_clock, PS2_data, rd_en, clear_err;
   logic [7:0] Key_code;
   logic       valid;
   logic [2:0] count;
   logic       overflow, frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   int err_seen = 0;
   int exp_err  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   ps2_rx_fifo #(
      .SYNC_STAGES   (SYNC),
      .FILTER_LEN    (FLEN),
      .TIMEOUT_CYCLES(TMO),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .PS2_clock(PS2_clock),
      .PS2_data (PS2_data),
      .rd_en    (rd_en),
      .clear_err(clear_err),
      .Key_code (Key_code),
      .valid    (valid),
      .count    (count),
      .overflow (overflow),
      .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Bits go out LSB first: start, data, odd parity, stop.
   task automatic send_frame(input logic [7:0] d, input bit bad_par,
                             input int nbits, input bit pop_at_push);
      logic [10:0] f;
      f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         PS2_data = f[i];
         wait_cyc(HALF);
         PS2_clock = 1'b0;
         if (pop_at_push && i == 10) begin
            wait_cyc(SYNC + FLEN);
            rd_en = 1'b1;
            wait_cyc(1);
            rd_en = 1'b0;
            wait_cyc(HALF - SYNC - FLEN - 1);
         end else begin
            wait_cyc(HALF);
         end
         PS2_clock = 1'b1;
      end
      PS2_data = 1'b1;
      wait_cyc(HALF);
   endtask

   task automatic pop_n(input int n);
      rd_en = 1'b1;
      wait_cyc(n);
      rd_en = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (frame_err === 1'b1) err_seen++;
         if (rd_en === 1'b1 && valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL pop_unexpected: got %0h, expected none",
                        Key_code);
            end else begin
               exp_b = exp_q.pop_front();
               if (Key_code !== exp_b) begin
                  n_fail++;
                  $display("FAIL pop_data: got %0h, expected %0h",
                           Key_code, exp_b);
               end
            end
         end
      end
   end

   initial begin
      PS2_clock = 1'b1;
      PS2_data  = 1'b1;
      rd_en     = 1'b0;
      clear_err = 1'b0;
      reset     = 1'b1;
      wait_cyc(5);
      chk("rst_key", Key_code, 8'h00);
      chk("rst_valid", valid, 1'b0);
      chk("rst_count", count, 3'd0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      reset = 1'b0;
      wait_cyc(5);

      send_frame(8'h1C, 1'b0, 11, 1'b0);
      exp_q.push_back(8'h1C);
      chk("t1_valid", valid, 1'b1);
      chk("t1_count", count, 3'd1);
      chk("t1_key", Key_code, 8'h1C);
      chk("t1_err", err_seen, exp_err);
      pop_n(1);
      chk("t1_empty", valid, 1'b0);
      pop_n(2);
      chk("empty_pop_count", count, 3'd0);
      chk("empty_pop_key", Key_code, 8'h00);

      send_frame(8'h1C, 1'b1, 11, 1'b0);
`ifdef PS2_RX_PARITY_EN
      exp_err++;
      chk("par_err", err_seen, exp_err);
      chk("par_count", count, 3'd0);
`else
      exp_q.push_back(8'h1C);
      chk("par_err", err_seen, exp_err);
      chk("par_count", count, 3'd1);
      chk("par_key", Key_code, 8'h1C);
      pop_n(1);
`endif

      for (int v = 1; v <= 5; v++) begin
         send_frame(8'(v), 1'b0, 11, 1'b0);
         if (v <= 4) exp_q.push_back(8'(v));
      end
      chk("ovf_count", count, 3'd4);
      chk("ovf_flag", overflow, 1'b1);
      chk("ovf_key", Key_code, 8'h01);
      pop_n(4);
      chk("ovf_drain_valid", valid, 1'b0);
      chk("ovf_sticky", overflow, 1'b1);
      clear_err = 1'b1;
      wait_cyc(1);
      clear_err = 1'b0;
      chk("ovf_clear", overflow, 1'b0);

      for (int v = 1; v <= 4; v++) begin
         send_frame(8'(v), 1'b0, 11, 1'b0);
         exp_q.push_back(8'(v));
      end
      send_frame(8'h06, 1'b0, 11, 1'b1);
      exp_q.push_back(8'h06);
      chk("fullpop_count", count, 3'd4);
      chk("fullpop_ovf", overflow, 1'b0);
      chk("fullpop_key", Key_code, 8'h02);
      pop_n(4);
      chk("fullpop_valid", valid, 1'b0);
      chk("fullpop_drained", exp_q.size(), 0);

      send_frame(8'hFF, 1'b0, 5, 1'b0);
      wait_cyc(TMO + 5);
      exp_err++;
      chk("tmo_err", err_seen, exp_err);
      send_frame(8'hF0, 1'b0, 11, 1'b0);
      exp_q.push_back(8'hF0);
      chk("tmo_next_key", Key_code, 8'hF0);
      pop_n(1);

      PS2_clock = 1'b0;
      PS2_data  = 1'b0;
      wait_cyc(3);
      PS2_clock = 1'b1;
      PS2_data  = 1'b1;
      wait_cyc(30);
      chk("glitch_count", count, 3'd0);
      chk("glitch_err", err_seen, exp_err);
      send_frame(8'h33, 1'b0, 11, 1'b0);
      chk("glitch_next_count", count, 3'd1);
      chk("glitch_next_key", Key_code, 8'h33);

      send_frame(8'hA5, 1'b0, 6, 1'b0);
      reset = 1'b1;
      wait_cyc(2);
      chk("midrst_key", Key_code, 8'h00);
      chk("midrst_valid", valid, 1'b0);
      chk("midrst_count", count, 3'd0);
      chk("midrst_ovf", overflow, 1'b0);
      chk("midrst_ferr", frame_err, 1'b0);
      reset = 1'b0;
      wait_cyc(5);
      send_frame(8'h5A, 1'b0, 11, 1'b0);
      exp_q.push_back(8'h5A);
      chk("post_rst_key", Key_code, 8'h5A);
      chk("post_rst_count", count, 3'd1);
      pop_n(1);
      wait_cyc(2);
      chk("final_err", err_seen, exp_err);
      chk("final_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
